// File: rtl/slipstream_array_if.sv
// slipstream_array_if: sample/drive bundle for the slipstream fan array.
// Parameters must match the slipstream_array instance the bundle is attached to.
//
// Handshake: i_valid is a one-cycle strobe with no back-pressure (there is no
// ready). i_sweat, i_wind and i_mult are captured only on a rising i_clk edge
// where i_valid is high; at any other edge they are ignored. o_fan, o_duty
// and o_cooling are continuous status outputs with no qualifier.
interface slipstream_array_if #(
    parameter int NUM_FANS = 6,
    parameter int WIND_W   = 15,
    parameter int MULT_W   = 10
);
    logic                       i_valid;
    logic [6:0]                 i_sweat;
    logic [WIND_W-1:0]          i_wind;
    logic [NUM_FANS*MULT_W-1:0] i_mult;
    logic [NUM_FANS-1:0]        o_fan;
    logic [NUM_FANS*7-1:0]      o_duty;
    logic                       o_cooling;

    // Master drives the sample inputs and observes the fan status.
    modport master (
        output i_valid, i_sweat, i_wind, i_mult,
        input  o_fan, o_duty, o_cooling
    );

    // Slave is the fan array itself.
    modport slave (
        input  i_valid, i_sweat, i_wind, i_mult,
        output o_fan, o_duty, o_cooling
    );
endinterface

// File: rtl/slipstream_array.sv
// slipstream_array: per-fan PWM drive derived from wind magnitude, a per-fan
// direction multiplier and a sweat-driven cooling boost with hysteresis.
//
// Pipeline, counted from the i_clk edge that captures i_valid:
//   +1 edge : cooling FSM evaluates the captured sweat (o_cooling changes)
//   +2 edges: per-fan targets load, computed with the new cooling state
//   +3 edges: duty follows the target (slew off), or moves 1 per slew tick
// Each fan's PWM compare value is only reloaded when the shared counter wraps.
//
// Build option: define SLIPSTREAM_SLEW_EN to compile in the slew limiter
// (duty moves 1 count toward target every SLEW_DIV clocks). Without it the
// duty register copies the target every clock and no divider exists.
//
// The cooling FSM state is visible directly on o_cooling (1 = COOL).
module slipstream_array #(
    parameter int NUM_FANS   = 6,
    parameter int WIND_W     = 15,
    parameter int MULT_W     = 10,
    parameter int PWM_PERIOD = 100,
    parameter int SLEW_DIV   = 1000,
    parameter int SWEAT_ON   = 50,
    parameter int SWEAT_OFF  = 35
) (
    input  logic              i_clk,
    input  logic              i_rst,
    slipstream_array_if.slave bus
);

    localparam int PROD_W = WIND_W + MULT_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int CMP_W  = (CNT_W > 7) ? CNT_W : 7;

    localparam logic [6:0] ON_TH  = 7'(SWEAT_ON);
    localparam logic [6:0] OFF_TH = 7'(SWEAT_OFF);

    // Elaboration-time sanity checks on the configuration.
    if (NUM_FANS < 1 || NUM_FANS > 16) begin : g_bad_fans
        $error("slipstream_array: NUM_FANS must be 1..16");
    end
    if (PWM_PERIOD < 1 || SLEW_DIV < 1) begin : g_bad_period
        $error("slipstream_array: PWM_PERIOD and SLEW_DIV must be >= 1");
    end
    if (SWEAT_OFF > SWEAT_ON) begin : g_bad_hyst
        $error("slipstream_array: SWEAT_OFF must not exceed SWEAT_ON");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COOL = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_nxt;

    logic [6:0]                 s_sweat;
    logic [WIND_W-1:0]          s_wind;
    logic [NUM_FANS*MULT_W-1:0] s_mult;
    logic                       valid_q1;   // sample captured last edge: FSM evaluates
    logic                       valid_q2;   // FSM updated last edge: targets load

    logic [NUM_FANS-1:0][6:0]   tgt_nxt;
    logic [NUM_FANS-1:0][6:0]   target;
    logic [NUM_FANS-1:0][6:0]   duty;
    logic [NUM_FANS-1:0][6:0]   cmp;

    logic [CNT_W-1:0]           pwm_cnt;
    logic                       pwm_wrap;
    logic [NUM_FANS-1:0]        fan_pwm;

    // Capture the sample inputs on i_valid and track the pipeline strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s_sweat  <= '0;
            s_wind   <= '0;
            s_mult   <= '0;
            valid_q1 <= 1'b0;
            valid_q2 <= 1'b0;
        end else begin
            valid_q1 <= bus.i_valid;
            valid_q2 <= valid_q1;
            if (bus.i_valid) begin
                s_sweat <= bus.i_sweat;
                s_wind  <= bus.i_wind;
                s_mult  <= bus.i_mult;
            end
        end
    end

    // Cooling FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cooling FSM next state: hysteresis on the freshly captured sweat only.
    always_comb begin
        state_nxt = state;
        if (valid_q1) begin
            case (state)
                ST_IDLE: if (s_sweat >= ON_TH)  state_nxt = ST_COOL;
                ST_COOL: if (s_sweat <  OFF_TH) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Per-fan target arithmetic at full product width, clamped at the end.
    for (genvar k = 0; k < NUM_FANS; k++) begin : g_fan
        logic [MULT_W-1:0] mult_k;
        logic [PROD_W-1:0] prod;
        logic [SUM_W-1:0]  idle_q;
        logic [SUM_W-1:0]  cool_q;
        logic [6:0]        idle_t;
        logic [6:0]        cool_t;

        assign mult_k = s_mult[k*MULT_W +: MULT_W];
        assign prod   = PROD_W'(s_wind) * PROD_W'(mult_k);

        // Round half up: add half an LSB of the result before shifting.
        assign idle_q = SUM_W'((SUM_W'(prod) + SUM_W'(32'h0000_8000)) >> 16);
        assign cool_q = SUM_W'((SUM_W'(prod) + SUM_W'(32'h0001_0000)) >> 17);

        assign idle_t = (idle_q > SUM_W'(100)) ? 7'd100 : idle_q[6:0];
        // 50 + min(100, q) clamped to 100 saturates as soon as q reaches 50.
        assign cool_t = (cool_q >= SUM_W'(50)) ? 7'd100 : (7'd50 + cool_q[6:0]);

        assign tgt_nxt[k] = (state == ST_COOL) ? cool_t : idle_t;
    end

    // Targets load two edges after the sample, using the updated FSM state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            target <= '0;
        end else if (valid_q2) begin
            target <= tgt_nxt;
        end
    end

`ifdef SLIPSTREAM_SLEW_EN
    localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             slew_tick;

    assign slew_tick = (div_cnt == DIV_W'(SLEW_DIV - 1));

    // Free-running slew divider; one tick per SLEW_DIV clocks.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt <= '0;
        end else if (slew_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Step each duty one count toward its (registered, hence old) target per tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            duty <= '0;
        end else if (slew_tick) begin
            for (int k = 0; k < NUM_FANS; k++) begin
                if (duty[k] < target[k]) begin
                    duty[k] <= duty[k] + 7'd1;
                end else if (duty[k] > target[k]) begin
                    duty[k] <= duty[k] - 7'd1;
                end
            end
        end
    end
`else
    // Without slew limiting the duty follows the target one clock later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            duty <= '0;
        end else begin
            duty <= target;
        end
    end
`endif

    assign pwm_wrap = (pwm_cnt == CNT_W'(PWM_PERIOD - 1));

    // Shared PWM counter, 0..PWM_PERIOD-1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pwm_cnt <= '0;
        end else if (pwm_wrap) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + CNT_W'(1);
        end
    end

    // Reload compare values only at the wrap so a period is never cut short.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cmp <= '0;
        end else if (pwm_wrap) begin
            cmp <= duty;
        end
    end

    // Fan output high while the counter is below the latched duty.
    always_comb begin
        fan_pwm = '0;
        for (int k = 0; k < NUM_FANS; k++) begin
            fan_pwm[k] = (CMP_W'(pwm_cnt) < CMP_W'(cmp[k]));
        end
    end

    assign bus.o_fan     = fan_pwm;
    assign bus.o_duty    = duty;
    assign bus.o_cooling = (state == ST_COOL);

endmodule

// File: doc/slipstream_array.md
SLIPSTREAM_ARRAY -- requirements
Module: slipstream_array

Interface
REQ-001 SHALL have parameter NUM_FANS, default 6, number of fan channels (1..16).
REQ-002 SHALL have parameter WIND_W, default 15, wind magnitude width, unsigned Q7.8 percent.
REQ-003 SHALL have parameter MULT_W, default 10, per-fan direction multiplier width, unsigned Q2.8.
REQ-004 SHALL have parameter PWM_PERIOD, default 100, PWM clocks per period; duty in percent maps 1:1 to counts.
REQ-005 SHALL have parameter SLEW_DIV, default 1000, clocks between slew ticks.
REQ-006 SHALL have parameter SWEAT_ON, default 50, and SWEAT_OFF, default 35, the cooling hysteresis thresholds.
REQ-007 SHALL have port i_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port i_valid, input, 1, single-cycle strobe qualifying i_sweat, i_wind and i_mult.
REQ-010 SHALL have port i_sweat, input, 7, sweat level 0..127.
REQ-011 SHALL have port i_wind, input, WIND_W, wind magnitude.
REQ-012 SHALL have port i_mult, input, NUM_FANS*MULT_W, flattened multipliers; fan k uses bits [k*MULT_W +: MULT_W].
REQ-013 SHALL have port o_fan, output, NUM_FANS, PWM drive per fan.
REQ-014 SHALL have port o_duty, output, NUM_FANS*7, current applied duty per fan, 0..100.
REQ-015 SHALL have port o_cooling, output, 1, cooling state.

Function
REQ-016 Inputs SHALL be registered only on i_valid; without i_valid, sampled values and targets hold.
REQ-017 Cooling FSM SHALL have states IDLE and COOL: IDLE->COOL when sampled sweat >= SWEAT_ON; COOL->IDLE when sampled sweat < SWEAT_OFF; otherwise hold; evaluated in the cycle after i_valid.
REQ-018 In IDLE, target_k SHALL be min(100, round_half_up(wind*mult_k / 2^16)).
REQ-019 In COOL, target_k SHALL be min(100, 50 + min(100, round_half_up(wind*mult_k / 2^17))).
REQ-020 Products SHALL be computed at full WIND_W+MULT_W width with no intermediate truncation before clamping.
REQ-021 Target registers SHALL update 2 clocks after the i_valid edge; o_cooling SHALL update 1 clock after it.
REQ-022 A slew tick SHALL fire once every SLEW_DIV clocks from a free-running divider.
REQ-023 On each tick, duty_k SHALL move 1 toward target_k; equal values hold; no overshoot.
REQ-024 o_duty SHALL present duty_k directly.
REQ-025 A shared PWM counter SHALL run 0..PWM_PERIOD-1 and wrap to 0.
REQ-026 Each fan SHALL latch duty_k into its PWM compare register only when the counter wraps, so no period is glitched.
REQ-027 o_fan[k] SHALL be high while counter < latched duty: duty 0 gives constant low; duty >= PWM_PERIOD gives constant high.
REQ-028 If i_valid arrives on the same cycle as a slew tick, the tick SHALL use the old target.

Reset
REQ-029 While i_rst is high, o_fan, o_duty, o_cooling, targets, sample registers, PWM counter and slew divider SHALL be 0, and the FSM SHALL be IDLE.
REQ-030 Reset asserted mid-period or mid-ramp SHALL clear state immediately, independent of i_clk.
REQ-031 After release, the first PWM period SHALL start at counter 0.

Configuration
REQ-032 With macro SLIPSTREAM_SLEW_EN defined, slew limiting per REQ-022/023 SHALL be compiled in.
REQ-033 Without SLIPSTREAM_SLEW_EN, duty_k SHALL equal target_k one clock after the target update, and no slew divider logic SHALL exist.

Verification
REQ-034 Defaults, slew off: i_wind=0x3200 (50.0), all mult=0x100 (1.0), sweat=10 on i_valid -> o_duty=50 for all fans 3 clocks later; o_fan high 50 of every 100 clocks.
REQ-035 Same stimulus with sweat=60 -> o_cooling=1 after 1 clock; o_duty=75 (50+25).
REQ-036 Sweat sequence 60, 40, 34 -> o_cooling 1, 1, 0; then sweat 49 -> stays 0.
REQ-037 Saturation: i_wind=0x7FFF, mult=0x3FF -> o_duty=100 and o_fan constant high, in both IDLE and COOL.
REQ-038 Slew on, SLEW_DIV=1000: target steps 0->50 -> o_duty reaches 50 after 50000 clocks, +1 per tick; retarget to 20 mid-ramp at 30 -> ramps down, no overshoot.
REQ-039 Assert i_rst at counter 40 with duty 75 -> o_fan, o_duty and o_cooling go 0 asynchronously; after release, PWM restarts at 0.
